// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared widths, stall encodings and FSM states for inst_fetch (IC_ADEL_EN widens the bus)
package inst_fetch_pkg;

  localparam int          STALL_BUS_W      = 6;
  localparam logic        STOP             = 1'b1;
  localparam logic        NO_STOP          = 1'b0;
  localparam logic [31:0] ZERO_WORD        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

`ifdef IC_ADEL_EN
  localparam int IC_TO_ID_WD = 34;
`else
  localparam int IC_TO_ID_WD = 33;
`endif

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_REQ  = 2'd1,
    IF_WAIT = 2'd2,
    IF_HOLD = 2'd3
  } if_state_e;

endpackage

// File: rtl/inst_fetch_if.sv
// rtl/inst_fetch_if.sv - SRAM-like instruction memory request/response interface
interface inst_fetch_if;

  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  modport master (
    output inst_sram_req,
    output inst_sram_addr,
    input  inst_sram_addr_ok,
    input  inst_sram_data_ok,
    input  inst_sram_rdata
  );

  modport slave (
    input  inst_sram_req,
    input  inst_sram_addr,
    output inst_sram_addr_ok,
    output inst_sram_data_ok,
    output inst_sram_rdata
  );

endinterface

// File: rtl/inst_fetch_redirect_sel.sv
// rtl/inst_fetch_redirect_sel.sv - next-PC priority mux: flush, then branch, then sequential
module if_redirect_sel (
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        br_e,
  input  logic [31:0] br_addr,
  input  logic        advance,
  input  logic [31:0] pc,
  output logic        redirect,
  output logic [31:0] pc_next
);

  assign redirect = flush | br_e;

  always_comb begin
    pc_next = pc;
    if (flush) begin
      pc_next = new_pc;
    end else if (br_e) begin
      pc_next = br_addr;
    end else if (advance) begin
      pc_next = pc + 32'd4;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - IF stage: PC, one-outstanding SRAM fetch, stall hold buffer, redirect squash
// Optional misaligned-fetch (AdEL) reporting enabled by defining IC_ADEL_EN.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic [31:0]            new_pc,
  input  logic [STALL_BUS_W-1:0] stall,
  input  logic                   br_e,
  input  logic [31:0]            br_addr,
  output logic                   stallreq,
  inst_fetch_if.master           sram,
  output logic [IC_TO_ID_WD-1:0] ic_to_id_bus,
  output logic [31:0]            ic_inst
);

  if_state_e   state, state_nxt;
  logic [31:0] pc_r, pc_next;
  logic        cancel, cancel_nxt;
  logic [31:0] buf_pc, buf_inst;
  logic        redirect, advance, capture, stop, req;
  logic        out_valid;
  logic [31:0] out_pc, out_inst;
  logic        unused_stall;

`ifdef IC_ADEL_EN
  logic misalign, out_adel, buf_adel, adel_park, park_nxt;
  assign misalign = (pc_r[1:0] != 2'b00);
`endif

  assign stop         = (stall[1] == STOP);
  assign unused_stall = ^{stall[STALL_BUS_W-1:2], stall[0]};

  if_redirect_sel u_redirect_sel (
    .flush    (flush),
    .new_pc   (new_pc),
    .br_e     (br_e),
    .br_addr  (br_addr),
    .advance  (advance),
    .pc       (pc_r),
    .redirect (redirect),
    .pc_next  (pc_next)
  );

  always_comb begin
    state_nxt  = state;
    cancel_nxt = cancel;
    advance    = 1'b0;
    capture    = 1'b0;
    req        = 1'b0;
    stallreq   = 1'b0;
    out_valid  = 1'b0;
    out_pc     = ZERO_WORD;
    out_inst   = ZERO_WORD;
`ifdef IC_ADEL_EN
    out_adel   = 1'b0;
    park_nxt   = adel_park & ~redirect;
`endif
    case (state)
      IF_IDLE: state_nxt = IF_REQ;
      IF_REQ: begin
`ifdef IC_ADEL_EN
        // misaligned PC never reaches memory; it is reported once, then parks until redirected
        if (misalign) begin
          if (!adel_park && !redirect) begin
            out_valid = 1'b1;
            out_pc    = pc_r;
            out_adel  = 1'b1;
            if (stop) begin
              capture   = 1'b1;
              state_nxt = IF_HOLD;
            end else begin
              park_nxt  = 1'b1;
            end
          end
        end else
`endif
        begin
          req      = 1'b1;
          stallreq = 1'b1;
          if (sram.inst_sram_addr_ok) begin
            state_nxt = IF_WAIT;
            if (redirect) cancel_nxt = 1'b1;
          end
        end
      end
      IF_WAIT: begin
        stallreq = 1'b1;
        if (sram.inst_sram_data_ok) begin
          state_nxt  = IF_REQ;
          cancel_nxt = 1'b0;
          if (!cancel && !redirect) begin
            out_valid = 1'b1;
            out_pc    = pc_r;
            out_inst  = sram.inst_sram_rdata;
            stallreq  = 1'b0;
            if (stop) begin
              capture   = 1'b1;
              state_nxt = IF_HOLD;
            end else begin
              advance   = 1'b1;
            end
          end
        end else if (redirect) begin
          cancel_nxt = 1'b1;
        end
      end
      IF_HOLD: begin
        out_valid = 1'b1;
        out_pc    = buf_pc;
        out_inst  = buf_inst;
`ifdef IC_ADEL_EN
        out_adel  = buf_adel;
`endif
        if (redirect) begin
          state_nxt = IF_REQ;
        end else if (!stop) begin
          state_nxt = IF_REQ;
`ifdef IC_ADEL_EN
          if (buf_adel) park_nxt = 1'b1;
          else          advance  = 1'b1;
`else
          advance   = 1'b1;
`endif
        end
      end
      default: state_nxt = IF_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IF_IDLE;
      pc_r     <= RESET_PC;
      cancel   <= 1'b0;
      buf_pc   <= ZERO_WORD;
      buf_inst <= ZERO_WORD;
    end else begin
      state  <= state_nxt;
      pc_r   <= pc_next;
      cancel <= cancel_nxt;
      if (capture) begin
        buf_pc   <= out_pc;
        buf_inst <= out_inst;
      end
    end
  end

`ifdef IC_ADEL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_adel  <= 1'b0;
      adel_park <= 1'b0;
    end else begin
      adel_park <= park_nxt;
      if (capture) buf_adel <= out_adel;
    end
  end

  assign ic_to_id_bus = {out_adel, out_valid, out_pc};
`else
  assign ic_to_id_bus = {out_valid, out_pc};
`endif

  assign ic_inst             = out_inst;
  assign sram.inst_sram_req  = req;
  assign sram.inst_sram_addr = req ? pc_r : ZERO_WORD;

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - scoreboard bench for inst_fetch: sequential fetch, stall hold, redirects, async reset
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  logic                   clk;
  logic                   rst_n;
  logic                   flush;
  logic [31:0]            new_pc;
  logic [STALL_BUS_W-1:0] stall;
  logic                   br_e;
  logic [31:0]            br_addr;
  logic                   stallreq;
  logic [IC_TO_ID_WD-1:0] ic_to_id_bus;
  logic [31:0]            ic_inst;

  inst_fetch_if sram_if ();

  inst_fetch dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .new_pc       (new_pc),
    .stall        (stall),
    .br_e         (br_e),
    .br_addr      (br_addr),
    .stallreq     (stallreq),
    .sram         (sram_if.master),
    .ic_to_id_bus (ic_to_id_bus),
    .ic_inst      (ic_inst)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] sb_q[$];
  logic [63:0] sb_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ID consumes whenever the bus is valid and this stage is not stopped
  always @(negedge clk) begin
    if (rst_n && ic_to_id_bus[32] && stall[1] == NO_STOP) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected", {31'd0, ic_to_id_bus[32]}, 32'd0);
      end else begin
        sb_e = sb_q.pop_front();
        check("sb_pc", ic_to_id_bus[31:0], sb_e[63:32]);
        check("sb_inst", ic_inst, sb_e[31:0]);
      end
    end
  end

  task automatic do_fetch(input logic [31:0] exp_addr, input logic [31:0] inst, input int hold);
    check("req", {31'd0, sram_if.inst_sram_req}, 32'd1);
    check("req_addr", sram_if.inst_sram_addr, exp_addr);
    check("stallreq_req", {31'd0, stallreq}, 32'd1);
    sram_if.inst_sram_addr_ok = 1'b1;
    tick();
    sram_if.inst_sram_addr_ok = 1'b0;
    sram_if.inst_sram_data_ok = 1'b1;
    sram_if.inst_sram_rdata   = inst;
    stall = (hold > 0) ? 6'b000010 : 6'b000000;
    sb_q.push_back({exp_addr, inst});
    #1;
    check("pass_valid", {31'd0, ic_to_id_bus[32]}, 32'd1);
    check("pass_inst", ic_inst, inst);
    tick();
    sram_if.inst_sram_data_ok = 1'b0;
    for (int i = 0; i < hold; i++) begin
      if (i == hold - 1) stall = 6'b000000;
      #1;
      check("hold_valid", {31'd0, ic_to_id_bus[32]}, 32'd1);
      check("hold_pc", ic_to_id_bus[31:0], exp_addr);
      check("hold_inst", ic_inst, inst);
      check("hold_req", {31'd0, sram_if.inst_sram_req}, 32'd0);
      tick();
    end
    stall = 6'b000000;
  endtask

  initial begin
    rst_n   = 1'b0;
    flush   = 1'b0;
    new_pc  = 32'd0;
    stall   = '0;
    br_e    = 1'b0;
    br_addr = 32'd0;
    sram_if.inst_sram_addr_ok = 1'b0;
    sram_if.inst_sram_data_ok = 1'b0;
    sram_if.inst_sram_rdata   = 32'd0;
    tick();
    tick();
    check("rst_req", {31'd0, sram_if.inst_sram_req}, 32'd0);
    check("rst_valid", {31'd0, ic_to_id_bus[32]}, 32'd0);
    check("rst_stallreq", {31'd0, stallreq}, 32'd0);
    rst_n = 1'b1;
    tick();

    do_fetch(32'hBFC0_0000, 32'h2401_0001, 0);
    do_fetch(32'hBFC0_0004, 32'h8C22_0000, 3);

    // branch while the response is outstanding squashes it
    check("req_addr_seq", sram_if.inst_sram_addr, 32'hBFC0_0008);
    sram_if.inst_sram_addr_ok = 1'b1;
    tick();
    sram_if.inst_sram_addr_ok = 1'b0;
    br_e    = 1'b1;
    br_addr = 32'hBFC0_0100;
    tick();
    br_e = 1'b0;
    sram_if.inst_sram_data_ok = 1'b1;
    sram_if.inst_sram_rdata   = 32'hDEAD_BEEF;
    #1;
    check("cancel_valid", {31'd0, ic_to_id_bus[32]}, 32'd0);
    check("cancel_stallreq", {31'd0, stallreq}, 32'd1);
    tick();
    sram_if.inst_sram_data_ok = 1'b0;

    // flush beats branch in the same cycle
    check("br_target", sram_if.inst_sram_addr, 32'hBFC0_0100);
    flush   = 1'b1;
    new_pc  = 32'hBFC0_0380;
    br_e    = 1'b1;
    br_addr = 32'hBFC0_0100;
    tick();
    flush = 1'b0;
    br_e  = 1'b0;

    // branch coinciding with data_ok drops that delivery
    check("flush_target", sram_if.inst_sram_addr, 32'hBFC0_0380);
    sram_if.inst_sram_addr_ok = 1'b1;
    tick();
    sram_if.inst_sram_addr_ok = 1'b0;
    sram_if.inst_sram_data_ok = 1'b1;
    sram_if.inst_sram_rdata   = 32'h1234_5678;
    br_e    = 1'b1;
    br_addr = 32'hFFFF_FFFC;
    #1;
    check("redir_data_valid", {31'd0, ic_to_id_bus[32]}, 32'd0);
    tick();
    br_e = 1'b0;
    sram_if.inst_sram_data_ok = 1'b0;

    do_fetch(32'hFFFF_FFFC, 32'h3C1D_0000, 0);
    do_fetch(32'h0000_0000, 32'h1111_1111, 1);

    // asynchronous reset in WAIT, stale data_ok around the release
    check("req_addr_wrap", sram_if.inst_sram_addr, 32'h0000_0004);
    sram_if.inst_sram_addr_ok = 1'b1;
    tick();
    sram_if.inst_sram_addr_ok = 1'b0;
    sram_if.inst_sram_data_ok = 1'b1;
    sram_if.inst_sram_rdata   = 32'hBAD0_BAD0;
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_req", {31'd0, sram_if.inst_sram_req}, 32'd0);
    check("arst_valid", {31'd0, ic_to_id_bus[32]}, 32'd0);
    check("arst_stallreq", {31'd0, stallreq}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("stale_valid", {31'd0, ic_to_id_bus[32]}, 32'd0);
    sram_if.inst_sram_data_ok = 1'b0;
    do_fetch(32'hBFC0_0000, 32'h2402_0002, 2);

`ifdef IC_ADEL_EN
    br_e    = 1'b1;
    br_addr = 32'hBFC0_0102;
    tick();
    br_e = 1'b0;
    sb_q.push_back({32'hBFC0_0102, 32'h0000_0000});
    #1;
    check("adel_req", {31'd0, sram_if.inst_sram_req}, 32'd0);
    check("adel_valid", {31'd0, ic_to_id_bus[32]}, 32'd1);
    check("adel_bit", {31'd0, ic_to_id_bus[33]}, 32'd1);
    check("adel_pc", ic_to_id_bus[31:0], 32'hBFC0_0102);
    check("adel_inst", ic_inst, 32'd0);
    tick();
    check("adel_park_valid", {31'd0, ic_to_id_bus[32]}, 32'd0);
    check("adel_park_req", {31'd0, sram_if.inst_sram_req}, 32'd0);
    flush  = 1'b1;
    new_pc = 32'hBFC0_0380;
    tick();
    flush = 1'b0;
    do_fetch(32'hBFC0_0380, 32'h4200_0018, 0);
`endif

    tick();
    check("sb_drained", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
